// File: rtl/lab5_2_rr_mux_arbiter_if.sv
// Shared-channel bundle between four producers, the round-robin arbiter and one consumer.
// The master modport is the arbiter's view; slave is the producer/consumer side.
interface lab5_2_rr_mux_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [3:0]       req;
  logic [3:0]       ack;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       sel;
  logic             busy;

  modport master (
    input  in0, in1, in2, in3, req, out_ready,
    output ack, out, out_valid, sel, busy
  );

  modport slave (
    output in0, in1, in2, in3, req, out_ready,
    input  ack, out, out_valid, sel, busy
  );
endinterface

// File: rtl/lab5_2_rr_mux_arbiter.sv
// Round-robin arbiter steering one of four requesters onto a shared channel,
// holding each grant for up to MAX_BURST beats or until the requester withdraws.
module lab5_2_rr_mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  lab5_2_rr_mux_arbiter_if.master bus
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [WIDTH-1:0] mux_data;
  logic             out_valid;
  logic             xfer;
  logic             release_grant;

  // Scan downwards so the candidate closest to the priority pointer is written last and wins.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    mux_data = '0;
    case (sel_q)
      2'd0:    mux_data = bus.in0;
      2'd1:    mux_data = bus.in1;
      2'd2:    mux_data = bus.in2;
      2'd3:    mux_data = bus.in3;
      default: mux_data = '0;
    endcase
  end

  // On release the pointer moves past the current owner before re-arbitrating, so it ranks last.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    beat_cnt_d    = beat_cnt_q;
    out_valid     = 1'b0;
    xfer          = 1'b0;
    release_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d    = GRANT;
          sel_d      = pick(bus.req, ptr_q);
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        out_valid = bus.req[sel_q];
        xfer      = out_valid & bus.out_ready;
        if (xfer) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        release_grant = (xfer && (beat_cnt_q == LAST_BEAT)) || !out_valid;
        if (release_grant) begin
          ptr_d = sel_q + 2'd1;
          if (|bus.req) begin
            sel_d      = pick(bus.req, sel_q + 2'd1);
            beat_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out       = out_valid ? mux_data : '0;
  assign bus.ack       = xfer ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == GRANT);

endmodule
